spi_regfile: RTL

Parametrised SPI mode-0 peripheral exposing a bank of NUM_REGS control registers to the chip-level logic (output enables, PWM enables, duty cycle and future channels). Successor to the write-only 5-register SPI front-end: register count, address and data width are generics, frames are length-checked before commit, and an optional readback path drives CIPO. Sits between the external SPI pins and the PWM/output blocks.

---
 rtl/spi_regfile.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI mode-0 peripheral exposing a bank of control registers
//
// Purpose: receives length-checked SPI frames {rw, addr[ADDR_W], data[DATA_W]}
//          (MSB first) and commits writes into NUM_REGS registers of DATA_W
//          bits. Optional readback drives CIPO during the data phase of reads.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   SCLK, COPI   SPI clock (CPOL=0) and controller data, asynchronous to clk
//   nCS          SPI chip select, active low
//   CIPO         peripheral data out (readback), 0 when not driving read data
//   regs_out     register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe    one-cycle pulse when a write commits
//   wr_addr      address of the last committed write
//   frame_err    sticky flag: a malformed frame was dropped
// Config macro: SPI_READBACK_EN enables the read path; undefined ties CIPO to 0.
module spi_regfile #(
    parameter int SYNC_FLOPS = 2,
    parameter int NUM_REGS   = 5,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int HDR_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    // Stages [SYNC_FLOPS-1:0] synchronise; the extra top stage holds the
    // previous synchronised value for edge detection.
    logic [SYNC_FLOPS:0]   sclk_q;
    logic [SYNC_FLOPS:0]   ncs_q;
    logic [SYNC_FLOPS-1:0] copi_q;
    logic                  sclk_rise, ncs_rise, ncs_fall, ncs_s, copi_s;

    state_t               state, state_nxt;
    logic [FRAME_W-1:0]   shreg, shreg_in;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    regs [NUM_REGS];
    logic                 f_rw, addr_ok;
    logic [ADDR_W-1:0]    f_addr;
    logic [DATA_W-1:0]    f_data;
    logic                 do_restart, do_count, do_shift, do_commit, do_drop;

    // nCS chain resets low so that a chip select still held low when reset
    // releases produces no fall: a new frame needs a genuine nCS fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            ncs_q  <= '0;
            copi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_FLOPS-1:0], SCLK};
            ncs_q  <= {ncs_q[SYNC_FLOPS-1:0], nCS};
            copi_q <= {copi_q[SYNC_FLOPS-2:0], COPI};
        end
    end

    assign ncs_s     = ncs_q[SYNC_FLOPS-1];
    assign copi_s    = copi_q[SYNC_FLOPS-1];
    assign sclk_rise = sclk_q[SYNC_FLOPS-1] & ~sclk_q[SYNC_FLOPS];
    assign ncs_rise  = ncs_q[SYNC_FLOPS-1] & ~ncs_q[SYNC_FLOPS];
    assign ncs_fall  = ~ncs_q[SYNC_FLOPS-1] & ncs_q[SYNC_FLOPS];

    assign shreg_in = {shreg[FRAME_W-2:0], copi_s};
    assign f_rw     = shreg[FRAME_W-1];
    assign f_addr   = shreg[DATA_W +: ADDR_W];
    assign f_data   = shreg[DATA_W-1:0];
    assign addr_ok  = ({1'b0, f_addr} < (ADDR_W+1)'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // nCS fall beats everything, nCS rise beats a same-cycle SCLK rise.
    always_comb begin
        state_nxt  = state;
        do_restart = 1'b0;
        do_count   = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        do_drop    = 1'b0;
        if (ncs_fall) begin
            do_restart = 1'b1;
            state_nxt  = S_CMD;
        end else if (ncs_rise) begin
            state_nxt = S_IDLE;
            if (state == S_DONE)
                do_commit = (cnt == CNT_W'(FRAME_W)) && f_rw && addr_ok;
            else if (state == S_CMD || state == S_DATA)
                do_drop = 1'b1;
        end else if (sclk_rise && !ncs_s && state != S_IDLE) begin
            do_count = 1'b1;
            do_shift = (state != S_DONE);
            case (state)
                S_CMD:  if (cnt == CNT_W'(HDR_W - 1))   state_nxt = S_DATA;
                S_DATA: if (cnt == CNT_W'(FRAME_W - 1)) state_nxt = S_DONE;
                S_DONE: begin
                    state_nxt = S_IDLE;
                    do_drop   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= do_commit;
            if (do_restart) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (do_count) begin
                if (cnt != CNT_W'(FRAME_W + 1)) cnt <= cnt + 1'b1;
                if (do_shift) shreg <= shreg_in;
            end
            if (do_commit) begin
                wr_addr <= f_addr;
                for (int i = 0; i < NUM_REGS; i++)
                    if (f_addr == ADDR_W'(i)) regs[i] <= f_data;
            end
            if (do_drop) frame_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

`ifdef SPI_READBACK_EN
    logic              sclk_fall, rd_act;
    logic [DATA_W-1:0] rd_sh, rd_val;

    assign sclk_fall = ~sclk_q[SYNC_FLOPS-1] & sclk_q[SYNC_FLOPS];

    // Address bits are complete in shreg_in on the cycle that enters DATA.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (shreg_in[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
    end

    // The fall right after the last address bit must not shift: the MSB has
    // to stay on CIPO until the controller samples it on the next rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sh  <= '0;
            rd_act <= 1'b0;
        end else if (do_restart) begin
            rd_sh  <= '0;
            rd_act <= 1'b0;
        end else if (state == S_CMD && state_nxt == S_DATA) begin
            rd_act <= ~shreg_in[ADDR_W];
            rd_sh  <= shreg_in[ADDR_W] ? '0 : rd_val;
        end else if (sclk_fall && !ncs_s && state == S_DATA && cnt > CNT_W'(HDR_W)) begin
            rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
        end
    end

    assign CIPO = (state == S_DATA) & rd_act & rd_sh[DATA_W-1];
`else
    assign CIPO = 1'b0;
`endif

endmodule
